xadc_drp_responder: RTL and testbench

XADC_DRP_RESPONDER -- requirements
Module: xadc_drp_responder

---
 rtl/xadc_drp_pkg.sv | 12 +
 rtl/xadc_sample_timer.sv | 20 ++
 rtl/xadc_drp_responder.sv | 76 +++++++
 tb/tb_xadc_drp_responder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/xadc_drp_pkg.sv
// xadc_drp_pkg: DRP register addresses, configuration reset values and DRP FSM state type
package xadc_drp_pkg;
  localparam logic [6:0] ADDR_VAUX6 = 7'h16;
  localparam logic [6:0] ADDR_CFG0 = 7'h40;
  localparam logic [6:0] ADDR_CFG1 = 7'h41;
  localparam logic [6:0] ADDR_CFG2 = 7'h42;
  localparam logic [15:0] CFG0_RST = 16'h0016;
  localparam logic [15:0] CFG1_RST = 16'h0000;
  localparam logic [15:0] CFG2_RST = 16'h0400;
  localparam logic [4:0] CHANNEL_VAUX6 = 5'h16;
  typedef enum logic [1:0] {ST_IDLE, ST_READ_WAIT, ST_WRITE_WAIT} drp_state_t;
endpackage

// File: rtl/xadc_sample_timer.sv
// xadc_sample_timer: conversion period counter; ports clk, rst in; eoc (one-cycle end of conversion), busy out
module xadc_sample_timer #(
  parameter int SAMPLE_DIV = 100,
  parameter int BUSY_CYCLES = 26
) (
  input  logic clk,
  input  logic rst,
  output logic eoc,
  output logic busy
);
  localparam int CW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else cnt <= eoc ? '0 : cnt + CW'(1);
  always_comb begin
    eoc = cnt == CW'(SAMPLE_DIV - 1);
    busy = cnt >= CW'(SAMPLE_DIV - 1 - BUSY_CYCLES) && cnt <= CW'(SAMPLE_DIV - 2);
  end
endmodule

// File: rtl/xadc_drp_responder.sv
// xadc_drp_responder: XADC DRP slave model; sample_in/DRP requests (daddr_in, den_in, dwe_in, di_in) in; do_out, drdy_out, eoc_out, busy_out, channel_out, protocol_err out
module xadc_drp_responder
  import xadc_drp_pkg::*;
#(
  parameter int SAMPLE_DIV = 100,
  parameter int BUSY_CYCLES = 26,
  parameter int READ_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sample_in,
  input  logic [6:0]  daddr_in,
  input  logic        den_in,
  input  logic        dwe_in,
  input  logic [15:0] di_in,
  output logic [15:0] do_out,
  output logic        drdy_out,
  output logic        eoc_out,
  output logic        busy_out,
  output logic [4:0]  channel_out,
  output logic        protocol_err
);
  localparam int LW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;
  drp_state_t state, state_nx;
  logic [LW-1:0] wcnt;
  logic [15:0] result, cfg0, cfg1, cfg2, rdata, rd_cap, wd_cap, do_q;
  logic [6:0] addr_cap;
  logic accept, last;
  xadc_sample_timer #(.SAMPLE_DIV(SAMPLE_DIV), .BUSY_CYCLES(BUSY_CYCLES)) u_timer (
    .clk(clk), .rst(rst), .eoc(eoc_out), .busy(busy_out)
  );
  assign channel_out = CHANNEL_VAUX6;
  always_comb begin
    accept = state == ST_IDLE && den_in;
    last = state != ST_IDLE && wcnt == LW'(READ_LATENCY - 1);
    state_nx = accept ? (dwe_in ? ST_WRITE_WAIT : ST_READ_WAIT) : last ? ST_IDLE : state;
    rdata = daddr_in == ADDR_VAUX6 ? result :
            daddr_in == ADDR_CFG0 ? cfg0 :
            daddr_in == ADDR_CFG1 ? cfg1 :
            daddr_in == ADDR_CFG2 ? cfg2 : 16'h0000;
    drdy_out = last;
    // read data is presented in the drdy cycle itself, then held in do_q
    do_out = (last && state == ST_READ_WAIT) ? rd_cap : do_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      wcnt <= '0;
      result <= '0;
      cfg0 <= CFG0_RST;
      cfg1 <= CFG1_RST;
      cfg2 <= CFG2_RST;
      rd_cap <= '0;
      wd_cap <= '0;
      addr_cap <= '0;
      do_q <= '0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_nx;
      wcnt <= state == ST_IDLE ? '0 : wcnt + LW'(1);
      // rd_cap samples result before this edge's EOC update
      if (accept) begin
        addr_cap <= daddr_in;
        wd_cap <= di_in;
        rd_cap <= rdata;
      end
      if (last && state == ST_READ_WAIT) do_q <= rd_cap;
      if (last && state == ST_WRITE_WAIT) begin
        if (addr_cap == ADDR_CFG0) cfg0 <= wd_cap;
        if (addr_cap == ADDR_CFG1) cfg1 <= wd_cap;
        if (addr_cap == ADDR_CFG2) cfg2 <= wd_cap;
      end
      if (den_in && state != ST_IDLE) protocol_err <= 1'b1;
      if (eoc_out) result <= {sample_in, 4'h0};
    end
endmodule

// File: tb/tb_xadc_drp_responder.sv
// tb_xadc_drp_responder: directed self-checking bench for xadc_drp_responder
module tb_xadc_drp_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] sample_in = 12'hABC;
  logic [6:0] daddr_in = '0;
  logic den_in = 1'b0;
  logic dwe_in = 1'b0;
  logic [15:0] di_in = '0;
  logic [15:0] do_out;
  logic drdy_out, eoc_out, busy_out, protocol_err;
  logic [4:0] channel_out;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  xadc_drp_responder dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .daddr_in(daddr_in), .den_in(den_in),
    .dwe_in(dwe_in), .di_in(di_in), .do_out(do_out), .drdy_out(drdy_out), .eoc_out(eoc_out),
    .busy_out(busy_out), .channel_out(channel_out), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_read(input logic [6:0] a, input logic [15:0] exp, input string nm);
    int lat;
    daddr_in = a; dwe_in = 1'b0; den_in = 1'b1;
    tick;
    den_in = 1'b0;
    lat = 1;
    while (!drdy_out && lat < 20) begin tick; lat++; end
    n_cmp++;
    if (lat !== 4) begin n_bad++; $display("FAIL %s latency: got %0d want 4", nm, lat); end
    n_cmp++;
    if (do_out !== exp) begin n_bad++; $display("FAIL %s data: got %h want %h", nm, do_out, exp); end
    tick;
    n_cmp++;
    if (do_out !== exp || drdy_out !== 1'b0) begin
      n_bad++; $display("FAIL %s hold: do_out %h drdy %b want %h 0", nm, do_out, drdy_out, exp);
    end
  endtask

  task automatic do_write(input logic [6:0] a, input logic [15:0] d, input string nm);
    int lat;
    daddr_in = a; di_in = d; dwe_in = 1'b1; den_in = 1'b1;
    tick;
    den_in = 1'b0; dwe_in = 1'b0;
    lat = 1;
    while (!drdy_out && lat < 20) begin tick; lat++; end
    n_cmp++;
    if (lat !== 4) begin n_bad++; $display("FAIL %s latency: got %0d want 4", nm, lat); end
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    cyc = 0;
    n_cmp++;
    if ({eoc_out, busy_out, drdy_out, protocol_err} !== 4'b0000 || do_out !== 16'h0000 || channel_out !== 5'h16) begin
      n_bad++;
      $display("FAIL reset: eoc %b busy %b drdy %b perr %b do %h ch %h want 0 0 0 0 0000 16",
               eoc_out, busy_out, drdy_out, protocol_err, do_out, channel_out);
    end
  endtask

  task automatic test_timing;
    for (int i = 0; i < 300; i++) begin
      n_cmp++;
      if (eoc_out !== (cyc % 100 == 99) || busy_out !== (cyc % 100 >= 73 && cyc % 100 <= 98)) begin
        n_bad++;
        $display("FAIL timing cycle %0d: eoc %b busy %b want %b %b", cyc, eoc_out, busy_out,
                 cyc % 100 == 99, cyc % 100 >= 73 && cyc % 100 <= 98);
      end
      tick;
    end
  endtask

  task automatic test_basic_read;
    do_read(7'h16, 16'hABC0, "read_vaux6");
    do_read(7'h42, 16'h0400, "read_cfg2_default");
    do_read(7'h10, 16'h0000, "read_unmapped");
  endtask

  task automatic test_write_read;
    do_write(7'h41, 16'h1234, "write_cfg1");
    do_read(7'h41, 16'h1234, "read_cfg1");
    do_write(7'h16, 16'hFFFF, "write_vaux6");
    do_read(7'h16, 16'hABC0, "read_vaux6_after_write");
    do_write(7'h33, 16'hBEEF, "write_unmapped");
    do_read(7'h33, 16'h0000, "read_unmapped_after_write");
  endtask

  task automatic test_eoc_collision;
    int guard = 0;
    while (cyc % 100 != 98 && guard < 200) begin tick; guard++; end
    sample_in = 12'h123;
    tick;
    n_cmp++;
    if (eoc_out !== 1'b1) begin n_bad++; $display("FAIL collision_align: eoc %b want 1", eoc_out); end
    do_read(7'h16, 16'hABC0, "collision_read");
    do_read(7'h16, 16'h1230, "post_eoc_read");
  endtask

  task automatic test_protocol_err;
    int drdys = 0;
    daddr_in = 7'h41; dwe_in = 1'b0; den_in = 1'b1;
    tick;
    den_in = 1'b0;
    tick;
    den_in = 1'b1; daddr_in = 7'h40;
    tick;
    den_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (drdy_out) begin
        drdys++;
        n_cmp++;
        if (do_out !== 16'h1234) begin n_bad++; $display("FAIL perr_data: got %h want 1234", do_out); end
      end
      tick;
    end
    n_cmp++;
    if (drdys !== 1) begin n_bad++; $display("FAIL perr_drdy_count: got %0d want 1", drdys); end
    repeat (5) tick;
    n_cmp++;
    if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL perr_sticky: got %b want 1", protocol_err); end
  endtask

  task automatic test_reset_mid_op;
    int drdys = 0;
    daddr_in = 7'h40; di_in = 16'h5555; dwe_in = 1'b1; den_in = 1'b1;
    tick;
    den_in = 1'b0; dwe_in = 1'b0;
    tick;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin tick; drdys += drdy_out; end
    rst = 1'b0;
    cyc = 0;
    n_cmp++;
    if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL perr_cleared: got %b want 0", protocol_err); end
    for (int i = 0; i < 8; i++) begin drdys += drdy_out; tick; end
    n_cmp++;
    if (drdys !== 0) begin n_bad++; $display("FAIL abort_drdy: got %0d pulses want 0", drdys); end
    do_read(7'h40, 16'h0016, "read_cfg0_after_abort");
    do_read(7'h41, 16'h0000, "read_cfg1_after_reset");
    do_read(7'h16, 16'h0000, "read_result_after_reset");
  endtask

  initial begin
    test_reset;
    test_timing;
    test_basic_read;
    test_write_read;
    test_eoc_collision;
    test_protocol_err;
    test_reset_mid_op;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
